// File: rtl/product_accumulator.sv
// product_accumulator: sums FRAME unsigned 6-bit products from an upstream
// 3x3 multiplier into one frame sum, then holds that sum behind a
// valid/ready handshake until the downstream stage takes it. A synchronous
// clear abandons the current frame; frames counts completed frames mod 16.
module product_accumulator #(
  parameter int FRAME = 4,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       p,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [2:0]       cnt,
  output logic [3:0]       frames
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(FRAME - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_accept;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_plus_p;
  logic [SUM_W-1:0] sum_q;
  logic [2:0]       cnt_q;
  logic [3:0]       frames_q;

  // Products are unsigned; zero-extend into the sum width before adding.
  function automatic logic [SUM_W-1:0] widen_product(input logic [5:0] v);
    return SUM_W'(v);
  endfunction

  // SUM_W is sized so FRAME maximal products cannot overflow, so a plain
  // modular add is exact.
  function automatic logic [SUM_W-1:0] add_product(input logic [SUM_W-1:0] a,
                                                   input logic [5:0]       v);
    return a + widen_product(v);
  endfunction

  // Handshake decode: clear blocks acceptance in the same cycle it is seen.
  always_comb begin
    in_ready    = (state == ACC) && !clear;
    accept      = in_valid && in_ready;
    last_accept = accept && (cnt_q == LAST_IDX);
    acc_plus_p  = add_product(acc_q, p);
  end

  // Next-state: clear forces ACC from anywhere; the final product of a frame
  // moves to HOLD; the downstream handshake releases HOLD.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (last_accept) state_nxt = HOLD;
        HOLD:    if (sum_ready)   state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, product count, published sum and frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      frames_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (last_accept) begin
      sum_q    <= acc_plus_p;
      acc_q    <= '0;
      cnt_q    <= '0;
      frames_q <= frames_q + 4'd1;
    end else if (accept) begin
      acc_q <= acc_plus_p;
      cnt_q <= cnt_q + 3'd1;
    end
  end

  // Outputs are taken straight from registered state.
  always_comb begin
    sum       = sum_q;
    sum_valid = (state == HOLD);
    cnt       = cnt_q;
    frames    = frames_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based frame model.
module tb_product_accumulator;

  localparam int FRAME = 4;
  localparam int SUM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       p;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [SUM_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic [2:0]       cnt;
  logic [3:0]       frames;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: products of the open frame, whether a sum is pending, last sum.
  int m_q[$];
  bit m_hold;
  int m_sum;
  int m_frames;

  product_accumulator #(.FRAME(FRAME), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .p(p), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .cnt(cnt), .frames(frames)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge with the given inputs, then update the model.
  task automatic step(input bit iv, input int pp, input bit clr,
                      input bit sr, input bit rn);
    int tot;
    in_valid  = iv;
    p         = 6'(pp);
    clear     = clr;
    sum_ready = sr;
    rst_n     = rn;
    @(posedge clk);
    if (!rn) begin
      m_q.delete();
      m_hold   = 0;
      m_sum    = 0;
      m_frames = 0;
    end else if (clr) begin
      m_q.delete();
      m_hold = 0;
    end else if (!m_hold) begin
      if (iv) begin
        m_q.push_back(pp);
        if (m_q.size() == FRAME) begin
          tot = 0;
          foreach (m_q[i]) tot += m_q[i];
          m_sum    = tot;
          m_frames = (m_frames + 1) % 16;
          m_hold   = 1;
          m_q.delete();
        end
      end
    end else if (sr) begin
      m_hold = 0;
    end
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(in_ready),  int'(!m_hold && !clear));
      check("sum_valid", int'(sum_valid), int'(m_hold));
      check("sum",       int'(sum),       m_sum);
      check("cnt",       int'(cnt),       m_q.size());
      check("frames",    int'(frames),    m_frames);
    end
  end

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int prods[4];
    int n;
    rst_n = 1'b0; p = '0; in_valid = 1'b0; clear = 1'b0; sum_ready = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // Reset state
    check("rst_sum", int'(sum), 0);
    check("rst_sum_valid", int'(sum_valid), 0);
    check("rst_frames", int'(frames), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // 1,4,9,49 back to back with sum_ready high
    step(1, 1, 0, 1, 1);
    step(1, 4, 0, 1, 1);
    step(1, 9, 0, 1, 1);
    step(1, 49, 0, 1, 1);
    check("s31_sum", int'(sum), 63);
    check("s31_valid", int'(sum_valid), 1);
    check("s31_frames", int'(frames), 1);
    check("s31_in_ready_hold", int'(in_ready), 0);
    step(0, 0, 0, 1, 1);
    check("s31_valid_drop", int'(sum_valid), 0);
    check("s31_sum_kept", int'(sum), 63);

    // 49 x4 held with sum_ready low; pending 7 waits
    for (int i = 0; i < 4; i++) step(1, 49, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 7, 0, 0, 1);
      check("s32_sum_held", int'(sum), 196);
      check("s32_in_ready0", int'(in_ready), 0);
    end
    step(1, 7, 0, 1, 1);
    check("s32_cnt_after_release", int'(cnt), 0);
    step(1, 7, 0, 0, 1);
    check("s32_cnt1", int'(cnt), 1);
    step(0, 0, 1, 0, 1);

    // 6,12 then clear with in_valid=1 p=20, then 2,2,2,2
    step(1, 6, 0, 0, 1);
    step(1, 12, 0, 0, 1);
    check("s33_cnt2", int'(cnt), 2);
    step(1, 20, 1, 0, 1);
    check("s33_cnt_clr", int'(cnt), 0);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 1);
    check("s33_sum", int'(sum), 8);
    check("s33_valid", int'(sum_valid), 1);
    step(0, 0, 0, 1, 1);

    // Reset while holding 196
    for (int i = 0; i < 4; i++) step(1, 49, 0, 0, 1);
    check("s34_pre_sum", int'(sum), 196);
    step(0, 0, 0, 0, 0);
    check("s34_sum", int'(sum), 0);
    check("s34_valid", int'(sum_valid), 0);
    check("s34_frames", int'(frames), 0);
    check("s34_in_ready", int'(in_ready), 1);

    // 17 all-zero frames
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
      check("s35_sum0", int'(sum), 0);
      step(0, 0, 0, 1, 1);
    end
    check("s35_frames_wrap", int'(frames), 1);

    // 0,63,63,63 with random gaps
    prods[0] = 0; prods[1] = 63; prods[2] = 63; prods[3] = 63;
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) step(0, $urandom_range(0, 63), 0, 1, 1);
      step(1, prods[i], 0, 0, 1);
      check("s36_cnt", int'(cnt), (i + 1) % 4);
    end
    check("s36_sum", int'(sum), 189);
    step(0, 0, 0, 1, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) != 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter FRAME, default 4, meaning the number of products summed per frame (legal 2..8).
REQ-002 The block SHALL have parameter SUM_W, default 8, meaning the width of the frame sum; it SHALL be at least ceil(log2(FRAME*63+1)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: a synchronous, active-low reset.
REQ-005 The block SHALL have port p, input, 6 bits: the unsigned product from the upstream 3x3 multiplier.
REQ-006 The block SHALL have port in_valid, input, 1 bit: p holds a valid product.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts p this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: a synchronous command that abandons the current frame.
REQ-009 The block SHALL have port sum, output, SUM_W bits: the completed frame sum.
REQ-010 The block SHALL have port sum_valid, output, 1 bit: sum is valid.
REQ-011 The block SHALL have port sum_ready, input, 1 bit: the downstream stage takes sum.
REQ-012 The block SHALL have port cnt, output, 3 bits: the number of products accepted in the current frame.
REQ-013 The block SHALL have port frames, output, 4 bits: the count of completed frames, wrapping from 15 to 0.

Function
REQ-014 The FSM SHALL have two states, ACC and HOLD.
REQ-015 in_ready SHALL equal (state==ACC) && !clear, combinationally.
REQ-016 An accept SHALL be in_valid && in_ready sampled at a rising clk edge; no other condition SHALL change acc or cnt, except clear and reset.
REQ-017 An accept in ACC with cnt < FRAME-1 SHALL apply acc <= acc + p and cnt <= cnt + 1.
REQ-018 An accept in ACC with cnt == FRAME-1 SHALL apply sum <= acc + p, acc <= 0, cnt <= 0, frames <= frames + 1 (mod 16), and a transition to HOLD.
REQ-019 sum_valid SHALL be 1 exactly while in HOLD, beginning the cycle after the final accept (one-cycle latency).
REQ-020 In HOLD, sum SHALL stay stable and no product SHALL be accepted (in_ready = 0).
REQ-021 In HOLD with sum_ready = 1 at an edge, the FSM SHALL return to ACC; sum SHALL keep its last value and sum_valid SHALL drop.
REQ-022 sum_ready SHALL be ignored in ACC.
REQ-023 All arithmetic SHALL be unsigned and zero-extended to SUM_W; no overflow is possible under REQ-002, and p values 50..63 SHALL be accepted as-is.
REQ-024 clear = 1 at an edge in any state SHALL set acc = 0, cnt = 0, and state = ACC, dropping any pending sum (sum_valid = 0 next cycle); frames and sum SHALL be unchanged.
REQ-025 When clear and in_valid are both 1, clear SHALL win and the product SHALL be dropped (in_ready is already 0).
REQ-026 When clear and sum_ready are both 1 in HOLD, the result SHALL be identical to clear alone.
REQ-027 in_valid SHALL NOT need to be continuous; idle cycles between accepts SHALL not affect acc or cnt.

Reset
REQ-028 rst_n = 0 at an edge SHALL set state = ACC, acc = 0, cnt = 0, sum = 0, sum_valid = 0, and frames = 0, overriding clear and all handshakes.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n returns to 1, when clear = 0.
REQ-030 A reset mid-frame or in HOLD SHALL discard all partial and pending data with no output handshake.

Verification
REQ-031 Scenario: FRAME = 4, back-to-back products 1, 4, 9, 49 with sum_ready = 1 -> sum = 63 and sum_valid = 1 for exactly one cycle, one cycle after the 4th accept; frames = 1.
REQ-032 Scenario: products 49 x4 with sum_ready = 0 for 5 cycles -> sum = 196 is held and in_ready = 0 throughout; a 5th product of 7 is not accepted until sum_ready pulses, then it counts toward the next frame (cnt = 1).
REQ-033 Scenario: products 6, 12, then clear with in_valid = 1 and p = 20 -> cnt = 0, acc = 0, p = 20 is not accepted; next products 2, 2, 2, 2 -> sum = 8.
REQ-034 Scenario: rst_n = 0 asserted while in HOLD with sum = 196 -> next cycle sum = 0, sum_valid = 0, frames = 0, in_ready = 1.
REQ-035 Scenario: complete 17 frames of all-zero products -> frames wraps to 1 and every sum = 0.
REQ-036 Scenario: products 0, 63, 63, 63 with random in_valid gaps -> sum = 189; cnt sequence 1, 2, 3, 0.
